// File: rtl/counter_ctrl_pkg.sv
// Shared state encodings and constants for the run/pause/lap/clear sequencer.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        LAP     = 2'd2,
        PAUSED  = 2'd3
    } run_state_t;

    localparam logic [3:0] LAP_MAX = 4'd15;

    // The prescaler only advances while the counter is live (running or lap-frozen display).
    function automatic logic is_counting(input run_state_t s);
        return (s == RUNNING) || (s == LAP);
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector: one pulse per press, a held key yields a single event.
module edge_pulse (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/counter_run_controller.sv
// Run/pause/lap/clear sequencer: turns key presses into count-enable ticks, counter clears
// and a lap-frozen display value for the 16-bit counter feeding the hex digits.
module counter_run_controller
    import counter_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int PW       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_start,
    input  logic        key_lap,
    input  logic        key_clear,
    input  logic [15:0] q,
    output logic        toggle,
    output logic        counter_clr,
    output logic [15:0] disp_value,
    output logic [1:0]  state,
    output logic [3:0]  lap_cnt,
    output logic        wrapped
);

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic          start_p;
    logic          lap_p;
    logic          clear_p;
    logic          start_evt;
    logic          lap_evt;
    logic          clear_acc;
    logic [PW-1:0] prescaler;
    logic [15:0]   lap_reg;
    run_state_t    cur_state;

    edge_pulse u_start_edge (.clock(clock), .reset(reset), .level(key_start), .pulse(start_p));
    edge_pulse u_lap_edge   (.clock(clock), .reset(reset), .level(key_lap),   .pulse(lap_p));
    edge_pulse u_clear_edge (.clock(clock), .reset(reset), .level(key_clear), .pulse(clear_p));

    // Coinciding presses resolve as clear > start > lap; the losers are simply dropped.
    assign start_evt = start_p & ~clear_p;
    assign lap_evt   = lap_p & ~clear_p & ~start_p;
    assign clear_acc = clear_p & ((cur_state == IDLE) || (cur_state == PAUSED));

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state   <= IDLE;
            prescaler   <= '0;
            toggle      <= 1'b0;
            counter_clr <= 1'b1;
            disp_value  <= '0;
            lap_cnt     <= '0;
            wrapped     <= 1'b0;
            lap_reg     <= '0;
        end else begin
            toggle      <= 1'b0;
            counter_clr <= 1'b0;
            disp_value  <= (cur_state == LAP) ? lap_reg : q;

            if (is_counting(cur_state)) begin
                if (prescaler == TICK_LAST) begin
                    toggle    <= 1'b1;
                    prescaler <= '0;
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end

            if (toggle && (q == 16'hFFFF)) begin
                wrapped <= 1'b1;
            end

            unique case (cur_state)
                IDLE: begin
                    if (start_evt) cur_state <= RUNNING;
                end
                RUNNING: begin
                    if (start_evt) begin
                        cur_state <= PAUSED;
                    end else if (lap_evt) begin
                        cur_state <= LAP;
                        lap_reg   <= q;
                        if (lap_cnt != LAP_MAX) lap_cnt <= lap_cnt + 4'd1;
                    end
                end
                LAP: begin
                    if (start_evt)    cur_state <= PAUSED;
                    else if (lap_evt) cur_state <= RUNNING;
                end
                PAUSED: begin
                    if (start_evt) cur_state <= RUNNING;
                end
            endcase

            // A clear overrides everything above, including a same-cycle wrap or tick.
            if (clear_acc) begin
                cur_state   <= IDLE;
                counter_clr <= 1'b1;
                prescaler   <= '0;
                lap_cnt     <= '0;
                wrapped     <= 1'b0;
            end
        end
    end

    assign state = cur_state;

endmodule
